// File: rtl/elink_tx_arbiter_if.sv
// Bundle of emesh transmit-channel inputs and the arbitrated elink-side output.
// The slave modport is the arbiter view; master is the surrounding fabric.
interface elink_tx_arbiter_if #(
    parameter int unsigned NCH = 3,
    parameter int unsigned PW  = 104,
    parameter int unsigned CW  = $clog2(NCH)
);
    logic [NCH-1:0]    in_access;
    logic [NCH*PW-1:0] in_packet;
    logic [NCH-1:0]    in_wait;
    logic              out_access;
    logic [PW-1:0]     out_packet;
    logic [CW-1:0]     out_channel;
    logic              out_wait;
    logic [31:0]       xfer_count;

    modport master (
        output in_access, in_packet, out_wait,
        input  in_wait, out_access, out_packet, out_channel, xfer_count
    );

    modport slave (
        input  in_access, in_packet, out_wait,
        output in_wait, out_access, out_packet, out_channel, xfer_count
    );
endinterface

// File: rtl/elink_tx_arbiter.sv
// Merges NCH emesh transmit channels into one registered elink packet stream,
// with fixed-priority or round-robin arbitration and downstream backpressure.
module elink_tx_arbiter #(
    parameter int unsigned NCH  = 3,
    parameter int unsigned PW   = 104,
    parameter int unsigned MODE = 1,
    parameter int unsigned CW   = $clog2(NCH)
) (
    input logic              clock,
    input logic              reset,
    elink_tx_arbiter_if.slave bus
);
    logic           stall;
    logic           grant_valid;
    logic [CW-1:0]  grant;
    logic           xfer;
    logic [NCH-1:0] grant_onehot;

    logic           out_access_q, out_access_d;
    logic [PW-1:0]  out_packet_q, out_packet_d;
    logic [CW-1:0]  out_channel_q, out_channel_d;
    logic [CW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [31:0]    xfer_count_q, xfer_count_d;

    assign stall = out_access_q & bus.out_wait;

    // Search starts at rr_ptr in round-robin mode, at channel 0 in fixed-priority mode.
    always_comb begin : grant_search
        int unsigned base;
        grant_valid = 1'b0;
        grant       = '0;
        base        = (MODE == 1) ? 32'(rr_ptr_q) : 32'd0;
        for (int unsigned k = 0; k < NCH; k++) begin
            int unsigned idx;
            idx = base + k;
            if (idx >= NCH) idx = idx - NCH;
            if (!grant_valid && bus.in_access[CW'(idx)]) begin
                grant_valid = 1'b1;
                grant       = CW'(idx);
            end
        end
    end

    always_comb begin
        grant_onehot        = '0;
        grant_onehot[grant] = 1'b1;
        xfer                = grant_valid & ~stall & ~reset;
        if (reset || stall) begin
            bus.in_wait = '1;
        end else if (grant_valid) begin
            bus.in_wait = ~grant_onehot;
        end else begin
            bus.in_wait = '0;
        end
    end

    always_comb begin
        out_access_d  = out_access_q;
        out_packet_d  = out_packet_q;
        out_channel_d = out_channel_q;
        rr_ptr_d      = rr_ptr_q;
        xfer_count_d  = xfer_count_q + 32'(xfer);
        if (!stall) begin
            out_access_d = |bus.in_access;
            if (grant_valid) begin
                out_packet_d  = bus.in_packet[32'(grant)*PW +: PW];
                out_channel_d = grant;
            end
        end
        if (MODE == 1 && xfer) begin
            rr_ptr_d = (grant == CW'(NCH - 1)) ? '0 : grant + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_access_q  <= 1'b0;
            out_packet_q  <= '0;
            out_channel_q <= '0;
            rr_ptr_q      <= '0;
            xfer_count_q  <= '0;
        end else begin
            out_access_q  <= out_access_d;
            out_packet_q  <= out_packet_d;
            out_channel_q <= out_channel_d;
            rr_ptr_q      <= rr_ptr_d;
            xfer_count_q  <= xfer_count_d;
        end
    end

    assign bus.out_access  = out_access_q;
    assign bus.out_packet  = out_packet_q;
    assign bus.out_channel = out_channel_q;
    assign bus.xfer_count  = xfer_count_q;
endmodule
